// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    sel_t             s;
    logic             valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  s,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output s,
        output valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin search: first set request at or above ptr, wrapping 7 to 0.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic             any,
    output sel_t             idx
);
    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    sel_t               offset;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[N_REQ-1:0];
        any     = 1'b0;
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any    = 1'b1;
                offset = sel_t'(i);
            end
        end
        idx = offset + ptr;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with registered one-hot grant and select.
// Optional forced release after TIMEOUT_CYCLES of holding: define ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic        clock,
    input logic        reset,
    rr_arbiter8_if.slave bus
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
        $error("rr_arbiter8: TIMEOUT_CYCLES must be within 2..255");
    end

    arb_state_t       state, nextState;
    logic [N_REQ-1:0] grantReg, nextGrant;
    sel_t             selReg, nextSel;
    sel_t             ptr, nextPtr;
    sel_t             pickPtr;
    sel_t             pickIdx;
    logic             pickAny;
    logic             validReg;
    logic             timeoutReg;
    logic             forced;
    logic             releaseNow;

    assign releaseNow = (state == BUSY) && (bus.done || !bus.req[selReg] || forced);
    assign pickPtr    = releaseNow ? (selReg + sel_t'(1)) : ptr;

    rr_pick8 picker (
        .req (bus.req),
        .ptr (pickPtr),
        .any (pickAny),
        .idx (pickIdx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [7:0] holdCount;

    assign forced = (state == BUSY) && (holdCount == 8'(TIMEOUT_CYCLES - 1))
                  && !bus.done && bus.req[selReg];

    // Counter restarts with every grant, so it only measures the current owner's tenure.
    always_ff @(posedge clock) begin
        if (reset) begin
            holdCount  <= '0;
            timeoutReg <= 1'b0;
        end else begin
            timeoutReg <= forced;
            if (state == IDLE || releaseNow) begin
                holdCount <= '0;
            end else begin
                holdCount <= holdCount + 8'd1;
            end
        end
    end
`else
    assign forced     = 1'b0;
    assign timeoutReg = 1'b0;
`endif

    always_comb begin
        nextState = state;
        nextGrant = grantReg;
        nextSel   = selReg;
        nextPtr   = ptr;
        unique case (state)
            IDLE: begin
                if (pickAny) begin
                    nextState = BUSY;
                    nextGrant = N_REQ'(1) << pickIdx;
                    nextSel   = pickIdx;
                end
            end
            BUSY: begin
                if (releaseNow) begin
                    nextPtr = selReg + sel_t'(1);
                    if (pickAny) begin
                        nextGrant = N_REQ'(1) << pickIdx;
                        nextSel   = pickIdx;
                    end else begin
                        nextState = IDLE;
                        nextGrant = '0;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            grantReg <= '0;
            selReg   <= '0;
            ptr      <= '0;
            validReg <= 1'b0;
        end else begin
            state    <= nextState;
            grantReg <= nextGrant;
            selReg   <= nextSel;
            ptr      <= nextPtr;
            validReg <= (nextState == BUSY);
        end
    end

    assign bus.grant   = grantReg;
    assign bus.s       = selReg;
    assign bus.valid   = validReg;
    assign bus.timeout = timeoutReg;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8; the timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter8;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.grant !== 8'h00 || bus.valid !== 1'b0 || bus.s !== 3'd0 || bus.timeout !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle cycle %0d: grant=%b valid=%b s=%0d timeout=%b, want 0/0/0/0",
                         c, bus.grant, bus.valid, bus.s, bus.timeout);
            end
        end
    endtask

    task automatic test_switch();
        doReset();
        bus.req = 8'b0010_0100;
        step();
        checks++;
        if (bus.grant !== 8'b0000_0100 || bus.s !== 3'd2 || bus.valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_grant: grant=%b s=%0d valid=%b, want 00000100/2/1", bus.grant, bus.s, bus.valid);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.grant !== 8'b0010_0000 || bus.s !== 3'd5 || bus.valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL direct_switch: grant=%b s=%0d valid=%b, want 00100000/5/1", bus.grant, bus.s, bus.valid);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] wantGrant;
        doReset();
        bus.req = 8'hFF;
        step();
        for (int g = 0; g < 9; g++) begin
            wantGrant = 8'h01 << (g % 8);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (bus.s !== 3'(g % 8) || bus.grant !== wantGrant || bus.valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rotation g=%0d c=%0d: s=%0d grant=%b, want %0d/%b",
                             g, c, bus.s, bus.grant, g % 8, wantGrant);
                end
                bus.done = (c == 2);
                step();
            end
        end
        bus.done = 1'b0;
    endtask

    task automatic test_withdraw();
        doReset();
        bus.req = 8'b0000_1000;
        step();
        checks++;
        if (bus.s !== 3'd3) begin
            failures++;
            $display("[TB] FAIL withdraw_grant3: s=%0d, want 3", bus.s);
        end
        bus.req = 8'b1000_0000;
        step();
        checks++;
        if (bus.s !== 3'd7 || bus.grant !== 8'b1000_0000) begin
            failures++;
            $display("[TB] FAIL withdraw_to7: s=%0d grant=%b, want 7/10000000", bus.s, bus.grant);
        end
        bus.req  = 8'h00;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.grant !== 8'h00 || bus.s !== 3'd7) begin
            failures++;
            $display("[TB] FAIL withdraw_idle: valid=%b grant=%b s=%0d, want 0/0/7", bus.valid, bus.grant, bus.s);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.s !== 3'd7) begin
            failures++;
            $display("[TB] FAIL idle_done_ignored: valid=%b s=%0d, want 0/7", bus.valid, bus.s);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.req = 8'b0000_0001;
        step();
        bus.req = 8'b0001_0000;
        step();
        checks++;
        if (bus.s !== 3'd4 || bus.grant !== 8'b0001_0000) begin
            failures++;
            $display("[TB] FAIL midreset_setup: s=%0d grant=%b, want 4/00010000", bus.s, bus.grant);
        end
        bus.req  = 8'b0001_0001;
        bus.done = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        bus.done = 1'b0;
        checks++;
        if (bus.grant !== 8'h00 || bus.valid !== 1'b0 || bus.s !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midreset_drop: grant=%b valid=%b s=%0d, want 0/0/0", bus.grant, bus.valid, bus.s);
        end
        step();
        checks++;
        if (bus.s !== 3'd0 || bus.grant !== 8'b0000_0001) begin
            failures++;
            $display("[TB] FAIL midreset_regrant: s=%0d grant=%b, want 0/00000001", bus.s, bus.grant);
        end
        bus.req = 8'h00;
    endtask

    task automatic test_back_to_back();
        doReset();
        bus.req = 8'b0000_0010;
        step();
        bus.req = 8'b0000_1111;
        step();
        checks++;
        if (bus.s !== 3'd1 || bus.grant !== 8'b0000_0010) begin
            failures++;
            $display("[TB] FAIL hold_others1: s=%0d grant=%b, want 1/00000010", bus.s, bus.grant);
        end
        bus.req = 8'b1000_0011;
        step();
        checks++;
        if (bus.s !== 3'd1) begin
            failures++;
            $display("[TB] FAIL hold_others2: s=%0d, want 1", bus.s);
        end
        bus.done = 1'b1;
        step();
        checks++;
        if (bus.s !== 3'd7 || bus.grant !== 8'b1000_0000) begin
            failures++;
            $display("[TB] FAIL rotate_past_owner: s=%0d grant=%b, want 7/10000000", bus.s, bus.grant);
        end
        bus.req = 8'b1000_0000;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.s !== 3'd7 || bus.valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sole_rewin: s=%0d valid=%b, want 7/1", bus.s, bus.valid);
        end
        bus.req = 8'b0000_0011;
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        checks++;
        if (bus.s !== 3'd0 || bus.grant !== 8'b0000_0001) begin
            failures++;
            $display("[TB] FAIL wrap_to0: s=%0d grant=%b, want 0/00000001", bus.s, bus.grant);
        end
        bus.req = 8'h00;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int variant = 0; variant < 2; variant++) begin
            doReset();
            bus.req = 8'b0000_0011;
            step();
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (bus.s !== 3'd0 || bus.timeout !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL timeout_hold v=%0d k=%0d: s=%0d timeout=%b, want 0/0", variant, k, bus.s, bus.timeout);
                end
                bus.done = (variant == 1) && (k == 15);
                step();
            end
            bus.done = 1'b0;
            checks++;
            if (bus.s !== 3'd1 || bus.timeout !== 1'(variant == 0)) begin
                failures++;
                $display("[TB] FAIL timeout_release v=%0d: s=%0d timeout=%b, want 1/%0d", variant, bus.s, bus.timeout, variant == 0);
            end
            step();
            checks++;
            if (bus.s !== 3'd1 || bus.timeout !== 1'b0) begin
                failures++;
                $display("[TB] FAIL timeout_pulse_end v=%0d: s=%0d timeout=%b, want 1/0", variant, bus.s, bus.timeout);
            end
        end
        bus.req = 8'h00;
    endtask
`else
    task automatic test_timeout();
        logic sawTimeout;
        sawTimeout = 1'b0;
        doReset();
        bus.req = 8'b0000_0011;
        for (int k = 0; k < 40; k++) begin
            step();
            sawTimeout = sawTimeout | bus.timeout;
        end
        checks++;
        if (bus.s !== 3'd0 || sawTimeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_timeout: s=%0d sawTimeout=%b, want 0/0", bus.s, sawTimeout);
        end
        bus.req = 8'h00;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        test_reset();
        test_switch();
        test_rotation();
        test_withdraw();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 8:1 select datapath (3-bit select, eight inputs) among eight requesters.
- Registers a one-hot grant plus the matching 3-bit select code that drives the mux select.
- Holds the grant until the owner releases, then rotates priority.
- Sits between requester logic (register-file read ports, bus sources) and the shared mux in the 16-bit CPU datapath.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-bit select.
- TIMEOUT_CYCLES, 16, maximum hold cycles before forced release; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  8  request vector; bit i = requester i wants the resource.
- Done  input  1  owner releases the resource this cycle.
- Grant  output  8  registered one-hot grant; all zero when idle.
- S  output  3  registered binary index of the granted requester; drives the mux select.
- Valid  output  1  registered; high while a grant is held; equals |Grant.
- Timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset is synchronous and active-high on Clock. Reset values: Grant=0, S=0, Valid=0, Timeout=0, priority pointer ptr=0, state IDLE, hold counter=0.
- Reset mid-grant drops Grant on the next edge. Req and Done are ignored during that cycle.
- States:
  - IDLE: no grant held.
  - BUSY: one grant held.
- Pick function: the first set Req bit, searching from index ptr upward and wrapping 7 to 0. No set bit means no pick.
- IDLE:
  - If Req != 0, the next edge sets Grant=onehot(pick), S=pick, Valid=1, and moves to BUSY.
  - Latency is 1 cycle from Req to Grant.
  - Req == 0 stays in IDLE. Done is ignored.
- BUSY, release condition: Done=1, or Req[S]=0 (owner withdraws), or a forced timeout.
- BUSY, on release:
  - ptr <= S+1 modulo 8 (7 wraps to 0).
  - The pick for the same edge uses the rotated pointer and excludes nothing. A releasing owner that still asserts Req therefore re-wins only when no other Req bit is set.
  - If a pick exists, Grant/S switch directly with no idle bubble, and the state stays BUSY.
  - If no pick exists, Grant=0, Valid=0, S keeps its last value, and the state goes to IDLE.
- BUSY, no release: Grant, S and ptr hold. Changes on non-granted Req bits have no effect.
- Grant is always zero or one-hot, and S is always consistent with Grant when Valid=1.
- ptr updates only on release, never on the initial grant from IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width 8 clears on every new grant and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no other release, the edge performs a forced release (same rotation and re-pick rules) and Timeout=1 for exactly that one cycle.
  - Done asserted in the same cycle counts as a normal release, and Timeout stays 0.
- Undefined: no counter logic; Timeout tied to 0; grants are held indefinitely until Done or Req withdrawal.

Decomposition:
- Package arb_pkg:
  - constants N_REQ=8 and SEL_W=3;
  - typedef arb_state_t enum {IDLE, BUSY};
  - typedef sel_t logic[2:0].
- Sub-module rr_pick8: purely combinational.
  - Inputs: Req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Implements a rotate, priority-find, un-rotate search.
- The FSM, pointer and timeout counter live in the top level.

Test Plan:
- Reset then Req=8'b0000_0000 for 5 cycles -> Grant=0, Valid=0, S=0 throughout.
- Req=8'b0010_0100 from IDLE, ptr=0 -> after 1 cycle Grant=8'b0000_0100, S=2; pulse Done -> next edge Grant=8'b0010_0000, S=5, no idle cycle.
- All Req=8'hFF, Done pulsed every 3rd cycle -> grant sequence S=0,1,2,...,7,0, each held exactly 3 cycles.
- Owner 3 granted, Req[3] drops with Req=8'b1000_0000 -> next edge S=7; Req drops to 0 after Done -> Valid=0, S stays 7.
- Reset asserted while S=4 is granted -> next edge Grant=0, ptr=0; with Req=8'b0001_0001 held through reset, the first grant after reset is S=0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, Req=8'b0000_0011 held, no Done -> S=0 for 16 cycles, Timeout=1 for one cycle, then S=1. Same run with Done asserted on cycle 16 -> Timeout stays 0.
